// File: rtl/regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb
//   Multi-port general register file for the pipelined CPU. It has NR
//   combinational read ports and NW synchronous write ports. Write-to-read
//   bypass is optional, and register 0 can be hardwired to zero. A busy bit per
//   register is kept for the hazard unit. The ALU, MDU and load writeback
//   paths can each have a producer in flight, and the busy bits track them.
//
// Ports
//   clk       clock
//   reset     synchronous, active-high reset; clears registers and busy bits
//   ra        NR read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd        NR read data words, port i at [i*DATA_W +: DATA_W]
//   rbusy     busy bit of register ra[i] (registered state, never bypassed)
//   we        per-write-port enable; port NW-1 has the highest priority
//   wa        NW write addresses, packed like ra
//   wd        NW write data words, packed like rd
//   iss_en    a producer for register iss_addr has issued: mark it busy
//   iss_addr  destination register of that producer
//   flush     clear every busy bit (pipeline flush); register writes still land
//   busy_vec  full scoreboard state, bit r = register r busy
// -----------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NR       = 3,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NR*ADDR_W-1:0]     ra,
  output logic [NR*DATA_W-1:0]     rd,
  output logic [NR-1:0]            rbusy,
  input  logic [NW-1:0]            we,
  input  logic [NW*ADDR_W-1:0]     wa,
  input  logic [NW*DATA_W-1:0]     wd,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  // Unpacked views of the packed port buses.
  logic [ADDR_W-1:0] ra_a [NR];
  logic [ADDR_W-1:0] wa_a [NW];
  logic [DATA_W-1:0] wd_a [NW];

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  // wr_hit[r] : some enabled write port targets r this cycle.
  // iss_hit[r]: the issuing producer targets r this cycle.
  // With ZERO_REG, register 0 is masked out of both.
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  iss_hit;

  always_comb begin
    for (int i = 0; i < NR; i++) ra_a[i] = ra[i*ADDR_W +: ADDR_W];
    for (int j = 0; j < NW; j++) begin
      wa_a[j] = wa[j*ADDR_W +: ADDR_W];
      wd_a[j] = wd[j*DATA_W +: DATA_W];
    end
  end

  // NOTE: every variable written in always_comb gets a default before any
  // conditional assignment; otherwise the tool infers a latch to hold it.
  always_comb begin
    wr_hit  = '0;
    iss_hit = '0;
    for (int j = 0; j < NW; j++)
      if (we[j]) wr_hit[wa_a[j]] = 1'b1;
    if (iss_en) iss_hit[iss_addr] = 1'b1;
    if (ZERO_REG != 0) begin
      wr_hit[0]  = 1'b0;
      iss_hit[0] = 1'b0;
    end
  end

  // Register array. Ports are visited in ascending order. When two ports hit
  // the same address, the last non-blocking assignment wins. That gives the
  // higher-indexed port priority.
  // NOTE: the array is reset explicitly. Registers must read 0 after reset,
  // so this storage cannot be left uninitialised the way a RAM could be.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NW; j++)
        if (we[j] && !(ZERO_REG != 0 && wa_a[j] == '0))
          regs[wa_a[j]] <= wd_a[j];
    end
  end

  // Scoreboard. flush clears everything. A new issue beats a completing
  // write to the same register, because the new producer supersedes the old
  // one. Otherwise a write clears the bit, and the bit holds when neither
  // happens. Register 0 never sets under ZERO_REG because iss_hit[0] is masked.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset || flush) busy <= '0;
    else                busy <= iss_hit | (busy & ~wr_hit);
  end

  assign busy_vec = busy;

  // Read ports: array value, then the optional same-cycle bypass (the highest
  // matching write port wins), then the hardwired zero, which overrides both.
  always_comb begin
    logic [DATA_W-1:0] val;
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < NR; i++) begin
      val = regs[ra_a[i]];
      if (BYPASS != 0)
        for (int j = 0; j < NW; j++)
          if (we[j] && wa_a[j] == ra_a[i]) val = wd_a[j];
      if (ZERO_REG != 0 && ra_a[i] == '0) val = '0;
      rd[i*DATA_W +: DATA_W] = val;
      // The busy bit is the registered state. A bypassed read still reports
      // busy, and the hazard unit masks it with its own bypass match.
      rbusy[i] = busy[ra_a[i]];
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp_sb
//   Self-checking bench for regfile_mp_sb using the default parameters.
//   The driver sets the inputs just after a rising edge. It then computes the
//   expected outputs from a reference model and queues them. The monitor pops
//   one entry at each falling edge and compares it with the DUT outputs. The
//   model is updated at each rising edge using the inputs that were applied.
// -----------------------------------------------------------------------------
module tb_regfile_mp_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NR     = 3;
  localparam int NW     = 2;
  localparam int DEPTH  = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NR*ADDR_W-1:0]   ra;
  logic [NR*DATA_W-1:0]   rd;
  logic [NR-1:0]          rbusy;
  logic [NW-1:0]          we;
  logic [NW*ADDR_W-1:0]   wa;
  logic [NW*DATA_W-1:0]   wd;
  logic                   iss_en;
  logic [ADDR_W-1:0]      iss_addr;
  logic                   flush;
  logic [DEPTH-1:0]       busy_vec;

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR), .NW(NW),
    .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .busy_vec(busy_vec)
  );

  typedef struct {
    logic [NR*DATA_W-1:0] rd;
    logic [NR-1:0]        rbusy;
    logic [DEPTH-1:0]     busy;
    string                tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model state: plain array of register contents and busy flags.
  logic [DATA_W-1:0] m_reg  [DEPTH];
  bit                m_busy [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // ---- reference model ------------------------------------------------------
  // Value seen on a read port for address a under the current inputs.
  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (a == 0) return '0;              // hardwired zero beats everything
    v = m_reg[a];
    for (int j = 0; j < NW; j++)        // the highest matching writer is seen last
      if (we[j] && wa[j*ADDR_W +: ADDR_W] == a) v = wd[j*DATA_W +: DATA_W];
    return v;
  endfunction

  function automatic bit written(input int r);
    for (int j = 0; j < NW; j++)
      if (we[j] && int'(wa[j*ADDR_W +: ADDR_W]) == r) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_clock();
    bit nb [DEPTH];
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
      return;
    end
    for (int r = 0; r < DEPTH; r++) begin
      if (flush)                                nb[r] = 1'b0;
      else if (iss_en && iss_addr == r && r != 0) nb[r] = 1'b1;
      else if (written(r))                      nb[r] = 1'b0;
      else                                      nb[r] = m_busy[r];
    end
    for (int j = 0; j < NW; j++)
      if (we[j] && wa[j*ADDR_W +: ADDR_W] != 0)
        m_reg[wa[j*ADDR_W +: ADDR_W]] = wd[j*DATA_W +: DATA_W];
    for (int r = 0; r < DEPTH; r++) m_busy[r] = nb[r];
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    for (int i = 0; i < NR; i++) begin
      e.rd[i*DATA_W +: DATA_W] = model_read(ra[i*ADDR_W +: ADDR_W]);
      e.rbusy[i]               = m_busy[ra[i*ADDR_W +: ADDR_W]];
    end
    for (int r = 0; r < DEPTH; r++) e.busy[r] = m_busy[r];
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // ---- driver helpers -------------------------------------------------------
  task automatic idle();
    reset = 1'b0; we = '0; wa = '0; wd = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic set_ra(input int i, input logic [ADDR_W-1:0] a);
    ra[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic set_w(input int j, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    we[j] = 1'b1;
    wa[j*ADDR_W +: ADDR_W] = a;
    wd[j*DATA_W +: DATA_W] = d;
  endtask

  // One cycle: optionally queue expectations for the current inputs, then
  // let the edge happen and advance the model.
  task automatic step(input string tag, input bit chk = 1'b1);
    if (chk) push_exp(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  // ---- monitor --------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NR; i++) begin
          check($sformatf("%s rd%0d", e.tag, i), 64'(rd[i*DATA_W +: DATA_W]),
                64'(e.rd[i*DATA_W +: DATA_W]));
          check($sformatf("%s rbusy%0d", e.tag, i), 64'(rbusy[i]), 64'(e.rbusy[i]));
        end
        check($sformatf("%s busy_vec", e.tag), 64'(busy_vec), 64'(e.busy));
      end
    end
  end

  // ---- stimulus -------------------------------------------------------------
  initial begin
    idle();
    ra = '0;
    #1;
    reset = 1'b1;
    step("reset", 1'b0);
    step("reset", 1'b0);
    reset = 1'b0;

    // Every address reads as zero and not busy after reset.
    for (int a = 0; a < DEPTH; a++) begin
      for (int i = 0; i < NR; i++) set_ra(i, ADDR_W'((a + i) % DEPTH));
      step("post_reset");
    end

    // Same-address dual write: port 1 wins. Bypass also shows port 1.
    idle(); ra = '0;
    set_w(0, 5'd5, 32'h1111_1111);
    set_w(1, 5'd5, 32'h2222_2222);
    set_ra(0, 5'd5);
    step("dual_write_bypass");
    idle();
    step("dual_write_read");

    // Bypass from port 0 into read port 1, then the stored value.
    set_w(0, 5'd7, 32'hDEAD_BEEF);
    set_ra(1, 5'd7);
    step("bypass7");
    idle();
    step("stored7");

    // Writes to address 0 are never visible.
    set_w(0, 5'd0, 32'hFFFF_FFFF);
    set_ra(2, 5'd0);
    step("zero_bypass");
    idle();
    step("zero_after");

    // Scoreboard: issue, then issue+write race, then write clears.
    ra = '0; set_ra(0, 5'd9);
    iss_en = 1'b1; iss_addr = 5'd9;
    step("iss9");
    idle(); iss_en = 1'b1; iss_addr = 5'd9; set_w(1, 5'd9, 32'h0000_0099);
    step("iss9_and_write");
    idle(); set_w(0, 5'd9, 32'h0000_0909);
    step("write9_clears");
    idle();
    step("busy9_after");

    // Flush beats a same-cycle issue.
    set_ra(1, 5'd3); set_ra(2, 5'd6);
    iss_en = 1'b1; iss_addr = 5'd3; step("iss3");
    iss_addr = 5'd4;                step("iss4");
    flush = 1'b1; iss_addr = 5'd6;  step("flush_iss6");
    idle();                         step("after_flush");

    // Reset in the middle of a write discards it and clears the busy bits.
    set_w(0, 5'd12, 32'hAAAA_0000); set_ra(0, 5'd12);
    step("pre_reset_write");
    idle(); iss_en = 1'b1; iss_addr = 5'd12; step("iss12");
    idle(); reset = 1'b1; set_w(1, 5'd12, 32'h5555_5555); iss_en = 1'b1; iss_addr = 5'd13;
    step("reset_with_write");
    idle(); set_ra(1, 5'd13);
    step("after_mid_reset");

    // Randomised traffic. Addresses are often drawn from a small range so
    // that collisions, bypasses and issue/write races happen regularly.
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int j = 0; j < NW; j++)
        if ($urandom_range(0, 2) != 0)
          set_w(j, ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom),
                $urandom);
      for (int i = 0; i < NR; i++)
        set_ra(i, ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom));
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      flush    = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 63) == 0);
      step("rand");
    end

    idle();
    step("final");

    // Let the monitor drain the queue, with a bounded wait.
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    check("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor of the single-write, two-read general register file for the pipelined CPU.
- Provides NR combinational read ports and NW synchronous write ports.
- Write-to-read bypass is configurable; register 0 can be hardwired to zero.
- Adds a per-register busy scoreboard, used by the hazard unit for stall decisions when multiple writeback paths are in flight (ALU, MDU, load).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NR, 3, number of read ports.
- NW, 2, number of write ports; port NW-1 has the highest priority.
- ZERO_REG, 1, if 1, register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, if 1, same-cycle write data is forwarded to matching reads.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- ra, input, NR*ADDR_W, read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd, output, NR*DATA_W, read data, packed the same way.
- rbusy, output, NR, busy bit of register ra[i].
- we, input, NW, per-port write enable.
- wa, input, NW*ADDR_W, write addresses.
- wd, input, NW*DATA_W, write data.
- iss_en, input, 1, marks register iss_addr busy (producer issued).
- iss_addr, input, ADDR_W, destination register of the issued producer.
- flush, input, 1, clears all busy bits (pipeline flush).
- busy_vec, output, 2**ADDR_W, full scoreboard state.

Behaviour:
- Reset (synchronous, posedge clk with reset=1):
  - All registers become 0 and all busy bits become 0.
  - After reset: rd = 0 on all ports, rbusy = 0, busy_vec = 0.
  - reset overrides we, iss_en and flush in the same cycle.
- Write:
  - On posedge clk, for each port j with we[j]=1, REG[wa[j]] <= wd[j].
  - Two ports with the same address in the same cycle: the higher-indexed port wins and the lower write is dropped.
  - Writes to address 0 are ignored when ZERO_REG=1.
- Read (combinational, zero latency):
  - rd[i] = REG[ra[i]].
  - If BYPASS=1 and some port j has we[j]=1, wa[j]==ra[i] and (ra[i]!=0 or ZERO_REG=0), then rd[i] = wd[j] of the highest such j.
  - If ZERO_REG=1 and ra[i]==0, then rd[i] = 0, regardless of bypass.
- Scoreboard update, per register r on posedge clk when not in reset:
  - flush=1: busy[r] <= 0 for all r. flush overrides iss_en and clears.
  - Otherwise, if iss_en=1 and iss_addr==r: busy[r] <= 1. Set beats a same-cycle clear, because the new producer supersedes the old one.
  - Otherwise, if any we[j]=1 with wa[j]==r: busy[r] <= 0.
  - Otherwise busy[r] is held.
  - Register 0 stays 0 when ZERO_REG=1; iss_en to address 0 has no effect.
  - flush does not cancel same-cycle register writes.
- rbusy[i] = busy[ra[i]] (registered state, no bypass).
  - When BYPASS=1 and a write to ra[i] occurs this cycle, rbusy[i] is still 1 for that cycle. The hazard unit masks it using the bypass match.
- No storage is updated outside the clock edge. All outputs are functions of state and current inputs only.
- Implementation limits: NR <= 4, NW <= 3. Synthesises to LUT/FF; no RAM inference is required.

Test Plan:
- Reset, then read all 32 addresses on ports 0..2 -> rd=0, rbusy=0, busy_vec=0.
- we=2'b11, wa0=wa1=5, wd0=0x1111_1111, wd1=0x2222_2222; next cycle read ra0=5 -> 0x2222_2222 (port 1 priority).
- BYPASS=1: we[0]=1, wa0=7, wd0=0xDEAD_BEEF, ra1=7 in the same cycle -> rd1=0xDEAD_BEEF combinationally; after the edge with we=0 -> still 0xDEAD_BEEF.
- Write 0xFFFF_FFFF to address 0 with bypass active and ra2=0 -> rd2=0 both before and after the edge.
- Scoreboard sequence:
  - iss_en, iss_addr=9 -> busy_vec[9]=1.
  - Then we[1]=1, wa1=9 with iss_en, iss_addr=9 in the same cycle -> busy[9] remains 1.
  - Then we[0]=1, wa0=9 alone -> busy[9]=0.
- Set busy on r3 and r4, then flush=1 together with iss_en, iss_addr=6 -> busy_vec=0. Separately, assert reset in the middle of a write -> registers 0 and the write is discarded.
